// File: rtl/config_mem_seq.sv
// Configuration RAM with a host write port, a registered host read port and a streaming sequencer.
// Optional build macro CFG_END_MARKER_EN: end a stream early at the first END_MARKER entry.
module config_mem_seq #(
  parameter int unsigned       DATA_W     = 24,
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [DATA_W-1:0] END_MARKER = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_enable,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StFinish} state_e;

  logic [DATA_W-1:0] mem [Depth];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [DATA_W-1:0] fetch_word;

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_enable) begin
      mem[w_addr] <= w_data;
    end
  end

  // Host read sees the pre-write value on a same-cycle write to the same address.
  always_comb begin
    r_data_d = mem[r_addr];
  end

  // Sequencer's private read port, independent of the host port.
  always_comb begin
    fetch_word = mem[ptr_q];
  end

`ifndef CFG_END_MARKER_EN
  logic unused_end_marker;
  assign unused_end_marker = ^END_MARKER;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    m_data_d = m_data_q;
    m_addr_d = m_addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (count != '0) begin
            ptr_d   = base_addr;
            rem_d   = count;
            state_d = StFetch;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StFetch: begin
`ifdef CFG_END_MARKER_EN
        if (fetch_word == END_MARKER) begin
          state_d = StFinish;
        end else begin
          m_data_d = fetch_word;
          m_addr_d = ptr_q;
          state_d  = StPresent;
        end
`else
        m_data_d = fetch_word;
        m_addr_d = ptr_q;
        state_d  = StPresent;
`endif
      end
      StPresent: begin
        if (m_ready) begin
          rem_d = rem_q - (ADDR_W + 1)'(1);
          if (rem_q == (ADDR_W + 1)'(1)) begin
            state_d = StFinish;
          end else begin
            // Natural wrap from DEPTH-1 to 0.
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      rem_q    <= '0;
      m_data_q <= '0;
      m_addr_q <= '0;
      r_data_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      m_data_q <= m_data_d;
      m_addr_q <= m_addr_d;
      r_data_q <= r_data_d;
    end
  end

  assign r_data  = r_data_q;
  assign m_data  = m_data_q;
  assign m_addr  = m_addr_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StFinish);
  assign m_valid = (state_q == StPresent);

endmodule
